// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI-accessible byte memory.
package spi_mem_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 8;
    localparam logic CMD_READ = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        GET_CMD,
        DECODE,
        WRITE_DATA,
        WRITE_COMMIT,
        READ_LOAD,
        READ_DUMMY,
        READ_SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/spi_input_sync.sv
// Two-flop synchronizer for an asynchronous pin, with one-clk rising/falling edge pulses.
module spi_input_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_memory.sv
// SPI mode-0 slave byte memory: one command byte {addr, R/W} then one data byte per CS frame.
module spi_memory
    import spi_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk_pin,
    input  logic       cs_pin,
    output logic       miso_pin,
    input  logic       mosi_pin,
    output logic [3:0] leds
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CMD_W = ADDR_W + 1;
    localparam int MAX_W = (CMD_W > DATA_W) ? CMD_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_fall;
    logic mosi_s;

    spi_input_sync u_sclk_sync (
        .clk_i (clk), .rst_i (reset), .d_i (sclk_pin),
        .sync_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_input_sync u_cs_sync (
        .clk_i (clk), .rst_i (reset), .d_i (cs_pin),
        .sync_o(cs_s), .rise_o(), .fall_o(cs_fall)
    );

    spi_input_sync u_mosi_sync (
        .clk_i (clk), .rst_i (reset), .d_i (mosi_pin),
        .sync_o(mosi_s), .rise_o(), .fall_o()
    );

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CMD_W-1:0]    cmd_q, cmd_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic                miso_q, miso_d;
    logic [3:0]          leds_q, leds_d;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   rd_byte;

    assign rd_byte = mem_q[addr_q];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        data_d  = data_q;
        addr_d  = addr_q;
        out_d   = out_q;
        miso_d  = miso_q;
        leds_d  = leds_q;
        mem_we  = 1'b0;

        // CS release has priority over any SCLK edge seen in the same clk.
        if (cs_s && state_q != IDLE) begin
            state_d = IDLE;
            miso_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        cnt_d   = '0;
                        state_d = GET_CMD;
                    end
                end
                GET_CMD: begin
                    if (sclk_rise) begin
                        cmd_d = {cmd_q[CMD_W-2:0], mosi_s};
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(CMD_W - 1)) state_d = DECODE;
                    end
                end
                DECODE: begin
                    addr_d  = cmd_q[CMD_W-1:1];
                    cnt_d   = '0;
                    state_d = (cmd_q[0] == CMD_READ) ? READ_LOAD : WRITE_DATA;
                end
                WRITE_DATA: begin
                    if (sclk_rise) begin
                        data_d = {data_q[DATA_W-2:0], mosi_s};
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = WRITE_COMMIT;
                    end
                end
                WRITE_COMMIT: begin
                    mem_we  = 1'b1;
                    leds_d  = data_q[3:0];
                    state_d = DONE;
                end
                READ_LOAD: begin
                    out_d   = rd_byte;
                    leds_d  = rd_byte[3:0];
                    state_d = READ_DUMMY;
                end
                READ_DUMMY: begin
                    if (sclk_rise) begin
                        miso_d  = 1'b0;
                        state_d = READ_SHIFT;
                    end
                end
                READ_SHIFT: begin
                    // Bits launch on falling edges; leave only once the last one was sampled.
                    if (sclk_fall && cnt_q != CNT_W'(DATA_W)) begin
                        miso_d = out_q[DATA_W-1];
                        out_d  = {out_q[DATA_W-2:0], 1'b0};
                        cnt_d  = cnt_q + CNT_W'(1);
                    end else if (sclk_rise && cnt_q == CNT_W'(DATA_W)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    miso_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cmd_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            out_q   <= '0;
            miso_q  <= 1'b0;
            leds_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            out_q   <= out_d;
            miso_q  <= miso_d;
            leds_q  <= leds_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[addr_q] <= data_q;
        end
    end

    assign miso_pin = (state_q == READ_SHIFT) ? miso_q : 1'b0;
    assign leds     = leds_q;

    logic unused_sclk;
    assign unused_sclk = sclk_s;

endmodule

// File: tb/tb_spi_memory.sv
// Self-checking bench for spi_memory: SPI master tasks plus a byte-array reference model.
module tb_spi_memory;

    localparam int HALF = 80;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sclk_pin = 1'b0;
    logic       cs_pin = 1'b1;
    logic       mosi_pin = 1'b0;
    logic       miso_pin;
    logic [3:0] leds;

    int passed = 0;
    int total  = 0;

    logic [7:0] mem_m [128];
    logic [3:0] leds_m;

    spi_memory #(.ADDR_W(7), .DATA_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .sclk_pin(sclk_pin),
        .cs_pin  (cs_pin),
        .miso_pin(miso_pin),
        .mosi_pin(mosi_pin),
        .leds    (leds)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 128; i++) mem_m[i] = 8'h00;
        leds_m = 4'h0;
    endtask

    task automatic spi_bit(input logic mo, output logic mi);
        mosi_pin = mo;
        #HALF;
        mi = miso_pin;
        sclk_pin = 1'b1;
        #HALF;
        sclk_pin = 1'b0;
    endtask

    task automatic spi_start();
        cs_pin = 1'b0;
        #10;
    endtask

    task automatic spi_stop();
        #HALF;
        cs_pin = 1'b1;
        #HALF;
    endtask

    task automatic spi_write(input logic [6:0] a, input logic [7:0] d, input int nbits);
        logic [7:0] cmd;
        logic mi;
        cmd = {a, 1'b0};
        spi_start();
        for (int i = 0; i < 8; i++) spi_bit(cmd[7-i], mi);
        for (int i = 0; i < nbits; i++) spi_bit(d[7-i], mi);
        spi_stop();
        if (nbits == 8) begin
            mem_m[a] = d;
            leds_m   = d[3:0];
        end
    endtask

    // quiet is the OR of miso over the command, dummy and trailing bits.
    task automatic spi_read(input logic [6:0] a, input int extra,
                            output logic [7:0] rd, output logic quiet);
        logic [7:0] cmd;
        logic mi;
        cmd   = {a, 1'b1};
        quiet = 1'b0;
        rd    = 8'h00;
        spi_start();
        for (int i = 0; i < 8; i++) begin
            spi_bit(cmd[7-i], mi);
            quiet = quiet | mi;
        end
        spi_bit(1'($urandom_range(0, 1)), mi);
        quiet = quiet | mi;
        for (int i = 0; i < 8; i++) begin
            spi_bit(1'($urandom_range(0, 1)), mi);
            rd = {rd[6:0], mi};
        end
        for (int i = 0; i < extra; i++) begin
            spi_bit(1'($urandom_range(0, 1)), mi);
            quiet = quiet | mi;
        end
        spi_stop();
        leds_m = mem_m[a][3:0];
    endtask

    task automatic check_read(input string name, input logic [6:0] a, input int extra);
        logic [7:0] rd;
        logic quiet;
        spi_read(a, extra, rd, quiet);
        total++;
        if (rd !== mem_m[a]) $display("FAIL %s read[%0h]: got %02h expected %02h", name, a, rd, mem_m[a]);
        else passed++;
        total++;
        if (quiet !== 1'b0) $display("FAIL %s miso_idle[%0h]: got %b expected 0", name, a, quiet);
        else passed++;
        total++;
        if (leds !== leds_m) $display("FAIL %s leds: got %h expected %h", name, leds, leds_m);
        else passed++;
    endtask

    task automatic test_reset();
        model_clear();
        reset = 1'b1;
        #23;
        total++;
        if (miso_pin !== 1'b0 || leds !== 4'h0)
            $display("FAIL reset_outputs: got miso=%b leds=%h expected miso=0 leds=0", miso_pin, leds);
        else passed++;
        reset = 1'b0;
        #50;
        check_read("unwritten", 7'h10, 0);
    endtask

    task automatic test_write_read_ff();
        spi_write(7'h00, 8'hFF, 8);
        check_read("ff", 7'h00, 2);
    endtask

    task automatic test_patterns();
        spi_write(7'h7F, 8'hA5, 8);
        spi_write(7'h01, 8'h3C, 8);
        check_read("pat_7f", 7'h7F, 0);
        check_read("pat_01", 7'h01, 0);
        total++;
        if (leds !== 4'hC) $display("FAIL pat_leds: got %h expected c", leds);
        else passed++;
    endtask

    task automatic test_aborted_write();
        spi_write(7'h05, 8'hB7, 4);
        check_read("aborted", 7'h05, 0);
    endtask

    task automatic test_cs_high_toggle();
        logic seen;
        seen = 1'b0;
        cs_pin = 1'b1;
        for (int i = 0; i < 20; i++) begin
            mosi_pin = 1'($urandom_range(0, 1));
            #HALF;
            seen = seen | miso_pin;
            sclk_pin = ~sclk_pin;
        end
        sclk_pin = 1'b0;
        #HALF;
        total++;
        if (seen !== 1'b0) $display("FAIL cs_high_miso: got %b expected 0", seen);
        else passed++;
        check_read("cs_high_mem", 7'h00, 0);
    endtask

    task automatic test_reset_mid();
        logic [7:0] cmd;
        logic mi;
        spi_write(7'h02, 8'h55, 8);
        cmd = {7'h03, 1'b0};
        spi_start();
        for (int i = 0; i < 8; i++) spi_bit(cmd[7-i], mi);
        for (int i = 0; i < 3; i++) spi_bit(1'b1, mi);
        reset = 1'b1;
        #40;
        total++;
        if (miso_pin !== 1'b0 || leds !== 4'h0)
            $display("FAIL reset_mid_outputs: got miso=%b leds=%h expected miso=0 leds=0", miso_pin, leds);
        else passed++;
        reset = 1'b0;
        model_clear();
        for (int i = 0; i < 5; i++) spi_bit(1'b1, mi);
        #HALF;
        cs_pin = 1'b1;
        #HALF;
        total++;
        if (leds !== 4'h0) $display("FAIL reset_mid_leds: got %h expected 0", leds);
        else passed++;
        check_read("reset_02", 7'h02, 0);
        check_read("reset_03", 7'h03, 0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            spi_write(7'(i * 33 + 9), d, 8);
            check_read("b2b", 7'(i * 33 + 9), 1);
        end
    endtask

    task automatic test_random();
        logic [6:0] a;
        logic [7:0] d;
        for (int i = 0; i < 24; i++) begin
            a = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 2) != 0) begin
                d = 8'($urandom);
                spi_write(a, d, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : 8);
            end else begin
                check_read("random", a, 0);
            end
        end
        check_read("random_final", 7'h7F, 0);
    endtask

    initial begin
        test_reset();
        test_write_read_ff();
        test_patterns();
        test_aborted_write();
        test_cs_high_toggle();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, got %0d/%0d", passed, total);
        $fatal(1);
    end

endmodule
